// File: rtl/core_pkg.sv
// Shared types for the banked data scratchpad.
// Access sizes, controller states and the latched request bundle.
package core_pkg;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD,
    DWORD
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAS_WR,
    RESP
  } spm_state_e;

  typedef struct packed {
    logic      atomic;
    mem_size_e size;
    logic      uns;
  } spm_req_t;

endpackage

// File: rtl/spm_lane_align.sv
// Byte-lane steering for the scratchpad.
// Store enables/data shifted up, load lanes shifted down and extended.
module spm_lane_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] i_off,
  input  mem_size_e                 i_size,
  input  logic                      i_uns,
  input  logic [XLEN-1:0]           i_wdata,
  input  logic [XLEN-1:0]           i_rword,
  output logic [XLEN/8-1:0]         o_be,
  output logic [XLEN-1:0]           o_wdata,
  output logic [XLEN-1:0]           o_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam logic [7:0] XB = 8'(XLEN);

  logic [OW+2:0]   w_sh;
  logic [7:0]      w_nb;
  logic [NB-1:0]   w_mask;
  logic [XLEN-1:0] w_rsh;
  logic [XLEN-1:0] w_keep;
  logic [XLEN-1:0] w_top;
  logic            w_neg;

  // Lane masks and shifts derived from size and low address bits
  always_comb begin
    w_sh    = {i_off, 3'b000};
    w_nb    = 8'd8 << i_size;
    w_mask  = NB'((1 << (1 << i_size)) - 1);
    o_be    = w_mask << i_off;
    o_wdata = i_wdata << w_sh;
    w_rsh   = i_rword >> w_sh;
    w_keep  = (w_nb >= XB) ? '1 : ~({XLEN{1'b1}} << w_nb);
    w_top   = w_keep & ~(w_keep >> 1);
    w_neg   = ~i_uns & (|(w_rsh & w_top));
    o_rdata = (w_rsh & w_keep) | (w_neg ? ~w_keep : '0);
  end

endmodule

// File: rtl/banked_data_scratchpad.sv
// Single-port data scratchpad with load, store and compare-and-swap.
// One request in flight; response held until the consumer takes it.
module banked_data_scratchpad
  import core_pkg::*;
#(
  parameter int MEM_SIZE = 8192,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_atomic,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [XLEN-1:0]  req_cmp,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_error,
  output logic             rsp_cas_ok
);

  localparam int NB    = XLEN / 8;
  localparam int OW    = $clog2(NB);
  localparam int AW    = $clog2(MEM_SIZE);
  localparam int WORDS = MEM_SIZE / NB;
  localparam mem_size_e FULL = (XLEN == 64) ? DWORD : WORD;

  logic [XLEN-1:0]  r_mem [WORDS];
  spm_state_e       r_state;
  spm_state_e       w_next;
  spm_req_t         r_req;
  logic [AW-OW-1:0] r_idx;
  logic [OW-1:0]    r_off;
  logic [XLEN-1:0]  r_wdata;
  logic [XLEN-1:0]  r_cmp;
  logic [XLEN-1:0]  r_rd;

  mem_size_e        w_isz;
  logic             w_acc;
  logic             w_mis;
  logic             w_err;
  logic             w_hit;
  logic [AW-OW-1:0] w_iidx;
  logic [AW-OW-1:0] w_ridx;
  logic [OW-1:0]    w_off;
  mem_size_e        w_sz;
  logic [NB-1:0]    w_be;
  logic [XLEN-1:0]  w_wsh;
  logic [XLEN-1:0]  w_ext;
  logic             w_wen;
  logic [AW-OW-1:0] w_widx;
  logic [NB-1:0]    w_wbe;
  logic [XLEN-1:0]  w_wdat;

  assign w_isz     = mem_size_e'(req_size);
  assign req_ready = reset & (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign w_acc     = req_valid & req_ready;
  assign w_iidx    = req_addr[AW-1:OW];
  assign w_hit     = (r_rd == r_cmp);

  // Incoming request legality: alignment, size, range, CAS width
  always_comb begin
    w_mis = 1'b0;
    unique case (w_isz)
      BYTE:  w_mis = 1'b0;
      HALF:  w_mis = req_addr[0];
      WORD:  w_mis = |req_addr[1:0];
      DWORD: w_mis = (XLEN != 64) | (|req_addr[2:0]);
      default: w_mis = 1'b1;
    endcase
    w_err = w_mis
          | (req_addr >= XLEN'(MEM_SIZE))
          | (req_atomic & (w_isz != FULL));
  end

  // Lane logic sees the live request in IDLE, the latched one later
  always_comb begin
    w_off  = (r_state == IDLE) ? req_addr[OW-1:0] : r_off;
    w_sz   = (r_state == IDLE) ? w_isz : r_req.size;
    w_ridx = (r_state == IDLE) ? w_iidx : r_idx;
  end

  spm_lane_align #(.XLEN(XLEN)) u_align (
    .i_off   (w_off),
    .i_size  (w_sz),
    .i_uns   (r_req.uns),
    .i_wdata (req_wdata),
    .i_rword (r_rd),
    .o_be    (w_be),
    .o_wdata (w_wsh),
    .o_rdata (w_ext)
  );

  // Single write port: plain store at accept, or CAS hit in CAS_WR
  always_comb begin
    w_wen  = 1'b0;
    w_widx = r_idx;
    w_wbe  = '0;
    w_wdat = r_wdata;
    if (w_acc & ~w_err & ~req_atomic & req_we) begin
      w_wen  = 1'b1;
      w_widx = w_iidx;
      w_wbe  = w_be;
      w_wdat = w_wsh;
    end else if (reset & (r_state == CAS_WR) & w_hit) begin
      w_wen  = 1'b1;
      w_wbe  = '1;
    end
  end

  // Storage array with byte enables and registered read
  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wbe[b]) r_mem[w_widx][b*8 +: 8] <= w_wdat[b*8 +: 8];
      end
    end
    r_rd <= r_mem[w_ridx];
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Controller next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_err)                        w_next = RESP;
          else if (req_atomic | ~req_we)    w_next = RD;
          else                              w_next = RESP;
        end
      end
      RD:      w_next = r_req.atomic ? CAS_WR : RESP;
      CAS_WR:  w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the accepted request so later input changes are ignored
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req   <= '{atomic: 1'b0, size: BYTE, uns: 1'b0};
      r_idx   <= '0;
      r_off   <= '0;
      r_wdata <= '0;
      r_cmp   <= '0;
    end else if (w_acc) begin
      r_req   <= '{atomic: req_atomic, size: w_isz, uns: req_unsigned};
      r_idx   <= w_iidx;
      r_off   <= req_addr[OW-1:0];
      r_wdata <= req_wdata;
      r_cmp   <= req_cmp;
    end
  end

  // Response fields; frozen while in RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_rdata  <= '0;
      rsp_tag    <= '0;
      rsp_error  <= 1'b0;
      rsp_cas_ok <= 1'b0;
    end else if (w_acc) begin
      rsp_rdata  <= '0;
      rsp_tag    <= req_tag;
      rsp_error  <= w_err;
      rsp_cas_ok <= 1'b0;
    end else if ((r_state == RD) & ~r_req.atomic) begin
      rsp_rdata  <= w_ext;
    end else if (r_state == CAS_WR) begin
      rsp_rdata  <= r_rd;
      rsp_cas_ok <= w_hit;
    end
  end

endmodule

// File: tb/tb_banked_data_scratchpad.sv
// Bench for banked_data_scratchpad: directed table, corner sequences,
// and random traffic against a byte-array reference model.
module tb_banked_data_scratchpad;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_atomic;
  logic [31:0] req_addr, req_wdata, req_cmp;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [3:0]  req_tag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_tag;
  logic        rsp_error, rsp_cas_ok;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [0:8191];

  typedef struct {
    logic        we;
    logic        atomic;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cmp;
    logic [1:0]  size;
    logic        uns;
    logic [3:0]  tag;
    logic [31:0] e_rd;
    logic        e_err;
    logic        e_cas;
    int          e_lat;
  } vec_t;

  vec_t vt[12];

  always #5 clk = ~clk;

  banked_data_scratchpad #(.MEM_SIZE(8192), .XLEN(32), .TAG_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_atomic   (req_atomic),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_cmp      (req_cmp),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_tag      (rsp_tag),
    .rsp_error    (rsp_error),
    .rsp_cas_ok   (rsp_cas_ok)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, atomic, input logic [31:0] addr, wdata, cmp,
                              input logic [1:0] size, input logic uns, input logic [3:0] tag,
                              input logic [31:0] e_rd, input logic e_err, e_cas, input int e_lat);
    vec_t v;
    v.we = we; v.atomic = atomic; v.addr = addr; v.wdata = wdata; v.cmp = cmp;
    v.size = size; v.uns = uns; v.tag = tag;
    v.e_rd = e_rd; v.e_err = e_err; v.e_cas = e_cas; v.e_lat = e_lat;
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) w[b*8 +: 8] = ref_mem[a + b];
    return w;
  endfunction

  // Reference behaviour computed from the access rules on a byte array
  task automatic model(input logic we, atomic, input logic [31:0] addr, wdata, cmp,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rd, output logic err, cas, output int lat);
    int nb;
    longint unsigned val;
    nb  = 1 << size;
    err = (size == 2'd3) || ((addr % nb) != 0) || (addr >= 8192) || (atomic && size != 2'd2);
    rd  = '0;
    cas = 1'b0;
    if (err) begin
      lat = 1;
    end else if (atomic) begin
      rd = ref_word(addr);
      if (rd == cmp) begin
        for (int b = 0; b < 4; b++) ref_mem[addr + b] = wdata[b*8 +: 8];
        cas = 1'b1;
      end
      lat = 3;
    end else if (we) begin
      for (int b = 0; b < nb; b++) ref_mem[addr + b] = wdata[b*8 +: 8];
      lat = 1;
    end else begin
      val = 0;
      for (int b = 0; b < nb; b++) val = val | (longint'(ref_mem[addr + b]) << (8 * b));
      if (!uns && val >= (64'd1 << (8 * nb - 1))) val = val - (64'd1 << (8 * nb));
      rd  = val[31:0];
      lat = 2;
    end
  endtask

  task automatic drive(input logic we, atomic, input logic [31:0] addr, wdata, cmp,
                       input logic [1:0] size, input logic uns, input logic [3:0] tag);
    req_we = we; req_atomic = atomic; req_addr = addr; req_wdata = wdata;
    req_cmp = cmp; req_size = size; req_unsigned = uns; req_tag = tag;
    req_valid = 1'b1;
  endtask

  task automatic scramble();
    req_valid = 1'b0;
    req_we = $urandom; req_atomic = $urandom; req_addr = $urandom;
    req_wdata = $urandom; req_cmp = $urandom; req_size = $urandom;
    req_unsigned = $urandom; req_tag = $urandom;
  endtask

  task automatic wait_ready(input string nm, output bit ok);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = req_ready;
    if (!ok) chk({nm, " ready timeout"}, 0, 1);
  endtask

  // One full transaction: issue, measure latency, check, hold, release
  task automatic run(input string nm, input logic we, atomic, input logic [31:0] addr, wdata, cmp,
                     input logic [1:0] size, input logic uns, input logic [3:0] tag,
                     input logic [31:0] e_rd, input logic e_err, e_cas, input int e_lat, input int hold);
    bit ok;
    int lat;
    drive(we, atomic, addr, wdata, cmp, size, uns, tag);
    wait_ready(nm, ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    scramble();
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, " latency"}, lat, e_lat);
    chk({nm, " rdata"}, rsp_rdata, e_rd);
    chk({nm, " error"}, rsp_error, e_err);
    chk({nm, " cas_ok"}, rsp_cas_ok, e_cas);
    chk({nm, " tag"}, rsp_tag, tag);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, " hold"}, {rsp_valid, req_ready, rsp_error, rsp_cas_ok, rsp_tag, rsp_rdata},
          {1'b1, 1'b0, e_err, e_cas, tag, e_rd});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, " release"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic run_model(input string nm, input logic we, atomic, input logic [31:0] addr, wdata, cmp,
                           input logic [1:0] size, input logic uns, input logic [3:0] tag, input int hold);
    logic [31:0] rd;
    logic err, cas;
    int lat;
    model(we, atomic, addr, wdata, cmp, size, uns, rd, err, cas, lat);
    run(nm, we, atomic, addr, wdata, cmp, size, uns, tag, rd, err, cas, lat, hold);
  endtask

  initial begin
    logic [31:0] d_rd;
    logic        d_err, d_cas;
    int          d_lat;
    bit          ok;

    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    reset = 1'b0; rsp_ready = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {req_ready, rsp_valid, rsp_error, rsp_cas_ok, rsp_tag, rsp_rdata}, '0);
    reset = 1'b1;
    #1;
    chk("ready after reset", req_ready, 1'b1);

    for (int a = 0; a < 256; a += 4) run("clear", 1, 0, a, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0);
    run("clear top", 1, 0, 8188, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0);

    vt[0]  = mk(1, 0, 32'h10,   32'hDEADBEEF, 0, 2, 0, 4'h1, 32'h0,        0, 0, 1);
    vt[1]  = mk(0, 0, 32'h10,   0,            0, 2, 0, 4'h2, 32'hDEADBEEF, 0, 0, 2);
    vt[2]  = mk(1, 0, 32'h13,   32'h80,       0, 0, 0, 4'h3, 32'h0,        0, 0, 1);
    vt[3]  = mk(0, 0, 32'h13,   0,            0, 0, 0, 4'h4, 32'hFFFFFF80, 0, 0, 2);
    vt[4]  = mk(0, 0, 32'h13,   0,            0, 0, 1, 4'h5, 32'h00000080, 0, 0, 2);
    vt[5]  = mk(0, 0, 32'h10,   0,            0, 2, 0, 4'h6, 32'h80ADBEEF, 0, 0, 2);
    vt[6]  = mk(0, 1, 32'h20,   5,            0, 2, 0, 4'h7, 32'h0,        0, 1, 3);
    vt[7]  = mk(0, 1, 32'h20,   7,            0, 2, 0, 4'h8, 32'h5,        0, 0, 3);
    vt[8]  = mk(0, 0, 32'h20,   0,            0, 2, 0, 4'h9, 32'h5,        0, 0, 2);
    vt[9]  = mk(0, 0, 32'h11,   0,            0, 1, 0, 4'hB, 32'h0,        1, 0, 1);
    vt[10] = mk(0, 0, 32'h2000, 0,            0, 2, 0, 4'hC, 32'h0,        1, 0, 1);
    vt[11] = mk(0, 0, 32'h10,   0,            0, 2, 0, 4'hD, 32'h80ADBEEF, 0, 0, 2);

    for (int i = 0; i < 12; i++) begin
      model(vt[i].we, vt[i].atomic, vt[i].addr, vt[i].wdata, vt[i].cmp, vt[i].size, vt[i].uns,
            d_rd, d_err, d_cas, d_lat);
      run($sformatf("vec%0d", i), vt[i].we, vt[i].atomic, vt[i].addr, vt[i].wdata, vt[i].cmp,
          vt[i].size, vt[i].uns, vt[i].tag, vt[i].e_rd, vt[i].e_err, vt[i].e_cas, vt[i].e_lat, 0);
    end

    run("stall", 0, 0, 32'h10, 0, 0, 2, 0, 4'hA, 32'h80ADBEEF, 0, 0, 2, 5);

    drive(0, 1, 32'h20, 32'h9, 32'h5, 2, 0, 4'h3);
    wait_ready("cas reset", ok);
    if (ok) begin
      @(posedge clk); #1;
      scramble();
      reset = 1'b0;
      @(posedge clk); #1;
      chk("cas reset outputs", {req_ready, rsp_valid, rsp_error, rsp_cas_ok, rsp_tag, rsp_rdata}, '0);
      reset = 1'b1;
      #1;
      chk("cas reset ready", req_ready, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("cas reset no rsp", rsp_valid, 1'b0);
    end else begin
      req_valid = 1'b0;
    end
    run_model("after cas reset", 0, 0, 32'h20, 0, 0, 2, 0, 4'h4, 0);

    for (int i = 0; i < 300; i++) begin
      logic        we, at, uns;
      logic [1:0]  sz;
      logic [31:0] a, wd, cm, msk;
      int          r;
      r   = $urandom_range(0, 2);
      at  = (r == 2);
      we  = (r == 1);
      sz  = at ? (($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd2) : 2'($urandom);
      uns = $urandom;
      msk = ~((32'd1 << sz) - 1);
      r   = $urandom_range(0, 9);
      if (r < 7)       a = $urandom_range(0, 255) & msk;
      else if (r == 7) a = $urandom_range(0, 255);
      else if (r == 8) a = (8188 + $urandom_range(0, 3)) & msk;
      else             a = ($urandom_range(0, 1) == 0) ? 32'(8192 + $urandom_range(0, 255)) : 32'hFFFFFFFC;
      wd  = $urandom;
      cm  = $urandom;
      if (at && $urandom_range(0, 1) == 1 && a < 8189 && a[1:0] == 2'b00) cm = ref_word(a);
      run_model($sformatf("rand%0d", i), we, at, a, wd, cm, sz, uns, 4'($urandom), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_data_scratchpad.md
BANKED_DATA_SCRATCHPAD -- requirements
Module: banked_data_scratchpad

Interface
REQ-001 Parameter MEM_SIZE, default 8192, total bytes; power of two.
REQ-002 Parameter XLEN, default 32, data and address width; legal values 32 or 64.
REQ-003 Parameter TAG_W, default 4, width of the request tag echoed on the response.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-008 req_we  input  1  1=store, 0=load.
REQ-009 req_atomic  input  1  compare-and-swap (CAS); overrides req_we.
REQ-010 req_addr  input  XLEN  byte address.
REQ-011 req_wdata  input  XLEN  store data, or CAS swap value.
REQ-012 req_cmp  input  XLEN  CAS compare value.
REQ-013 req_size  input  2  00=byte, 01=half, 10=word, 11=dword (legal only when XLEN=64).
REQ-014 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-015 req_tag  input  TAG_W  request identifier.
REQ-016 rsp_valid  output  1  response present.
REQ-017 rsp_ready  input  1  consumer accepts the response.
REQ-018 rsp_rdata  output  XLEN  load data (extended), CAS old value, or 0 for a store or error.
REQ-019 rsp_tag  output  TAG_W  echo of req_tag.
REQ-020 rsp_error  output  1  misaligned access, illegal size, or out-of-range address.
REQ-021 rsp_cas_ok  output  1  CAS compare matched and the memory was written.

Function
REQ-022 Storage: MEM_SIZE/(XLEN/8) words with a synchronous read (1-cycle BRAM) and per-byte write enables; initial contents are zero.
REQ-023 FSM states:
- IDLE: the only state in which req_ready=1.
- RD: memory read cycle.
- CAS_WR: compare and conditional write.
- RESP: holds rsp_valid=1.
REQ-024 IDLE transitions on accept:
- Error: go to RESP with rsp_error=1 and no memory write.
- Store: write memory on the accept edge, then go to RESP.
- Load or CAS: go to RD.
REQ-025 RD transitions:
- Load: capture the extended lane data, then go to RESP; accept-to-rsp_valid latency is 2 cycles.
- CAS: go to CAS_WR.
REQ-026 CAS_WR: if the full word equals req_cmp, write req_wdata and set cas_ok=1; always return the old word; go to RESP; latency is 3 cycles.
REQ-027 RESP: while rsp_ready=0, the outputs stay stable; when rsp_ready=1, go to IDLE; req_ready rises in the following cycle.
REQ-028 The request fields are registered at accept; later changes on the req_* inputs have no effect on an accepted request.
REQ-029 Alignment rules:
- Half requires addr[0]=0.
- Word requires addr[1:0]=0.
- Dword requires addr[2:0]=0.
- Size 11 with XLEN=32 is an error.
- A CAS must be of full-XLEN size.
REQ-030 Range rule: addr >= MEM_SIZE is an error; there is no wrap-around.
REQ-031 Store byte-lane selection comes from the low address bits; bytes outside the selected lanes are unchanged.
REQ-032 Load extraction: shift the selected lane to bit 0, then sign- or zero-extend it to XLEN; a full-XLEN load is not extended.

Reset
REQ-033 reset=0 forces: state=IDLE, req_ready=0 in that cycle, rsp_valid=0, rsp_rdata=0, rsp_tag=0, rsp_error=0, rsp_cas_ok=0.
REQ-034 Reset asserted in RD, CAS_WR or RESP abandons the operation and generates no response; a CAS in RD is not written; memory contents are preserved.

Structure
REQ-035 core_pkg holds:
- the mem_size_e enum (BYTE, HALF, WORD, DWORD);
- the spm_state_e enum;
- the spm_req_t struct.
REQ-036 The lane extract/extend and byte-enable generation live in one combinational sub-module, spm_lane_align.

Verification
REQ-037 Scenario 1: XLEN=32; store word 0xDEADBEEF at 0x10, then load word 0x10 -> rsp_rdata=0xDEADBEEF, latency 2 cycles.
REQ-038 Scenario 2: store byte 0x80 at 0x13, then load byte 0x13 signed -> 0xFFFFFF80; load unsigned -> 0x00000080; load word 0x10 -> 0x80ADBEEF.
REQ-039 Scenario 3: CAS at 0x20 (holding 0) with cmp=0, wdata=5 -> rdata=0, cas_ok=1; repeat with cmp=0, wdata=7 -> rdata=5, cas_ok=0, and memory remains 5.
REQ-040 Scenario 4: load half 0x11 -> rsp_error=1, rdata=0; load word 0x2000 (MEM_SIZE=8192) -> rsp_error=1; memory unchanged.
REQ-041 Scenario 5: hold rsp_ready=0 for 5 cycles -> rsp_valid and the response fields stay stable and req_ready=0; the tag echo matches req_tag=0xA.
REQ-042 Scenario 6: reset=0 during RD of a CAS -> no response is produced and memory is unchanged; after release, req_ready=1.
